// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the iterative ALU.
package alu_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [4:0] {
    OP_AND   = 5'b00000,
    OP_OR    = 5'b00001,
    OP_ADD   = 5'b00010,
    OP_SLL   = 5'b00011,
    OP_SLT   = 5'b00100,
    OP_SLTU  = 5'b00101,
    OP_SUB   = 5'b00110,
    OP_XOR   = 5'b00111,
    OP_SRL   = 5'b01000,
    OP_SRA   = 5'b01010,
    OP_MUL   = 5'b10000,
    OP_MULH  = 5'b10001,
    OP_MULHU = 5'b10010,
    OP_DIV   = 5'b10011,
    OP_DIVU  = 5'b10100,
    OP_REM   = 5'b10101,
    OP_REMU  = 5'b10110
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the opcodes served by the multi-cycle multiply/divide unit.
  function automatic logic is_mop(input logic [4:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_mop = 1'b1;
      default: is_mop = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Request/result handshake bundle between an ALU client and iter_alu.
interface iter_alu_if #(
  parameter int XLEN = alu_pkg::XLEN_DEFAULT
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a1;
  logic [XLEN-1:0] a2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] y;
  logic            zero;
  logic            s_less;
  logic            u_less;
  logic            illegal;

  modport master (
    output in_valid, op, a1, a2, out_ready,
    input  in_ready, out_valid, y, zero, s_less, u_less, illegal
  );

  modport slave (
    input  in_valid, op, a1, a2, out_ready,
    output in_ready, out_valid, y, zero, s_less, u_less, illegal
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiply (shift-add) and restoring divide, one bit per cycle.
// done_o is high during the final iteration and result_o is then valid combinationally.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a1_i,
  input  logic [XLEN-1:0] a2_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic            is_div_q, hi_sel_q, rem_sel_q, neg_q, div_zero_q;
  logic [XLEN-1:0] acc_q, lo_q, opnd_q;
  logic [XLEN-1:0] acc_d, lo_d;

  // Operand decode at start: signed ops work on magnitudes and fix the sign at the end.
  logic            sgn, st_div, st_rem, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign sgn    = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign st_div = (op_i == OP_DIV) || (op_i == OP_DIVU) || (op_i == OP_REM) || (op_i == OP_REMU);
  assign st_rem = (op_i == OP_REM) || (op_i == OP_REMU);
  assign a_neg  = sgn & a1_i[XLEN-1];
  assign b_neg  = sgn & a2_i[XLEN-1];
  assign a_mag  = a_neg ? -a1_i : a1_i;
  assign b_mag  = b_neg ? -a2_i : a2_i;

  // Multiply step: acc holds the high half, lo the shrinking multiplier / growing low half.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_acc_d, mul_lo_d;

  assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc_d = mul_sum[XLEN:1];
  assign mul_lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};

  // Restoring divide step: acc is the partial remainder, lo shifts dividend out and quotient in.
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_acc_d, div_lo_d;

  assign div_shift = {acc_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[XLEN];
  assign div_acc_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_lo_d  = {lo_q[XLEN-2:0], div_ge};

  assign acc_d = is_div_q ? div_acc_d : mul_acc_d;
  assign lo_d  = is_div_q ? div_lo_d  : mul_lo_d;

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   div_mag, div_res;

  assign prod    = {mul_acc_d, mul_lo_d};
  assign prod_s  = neg_q ? -prod : prod;
  assign div_mag = rem_sel_q ? div_acc_d : div_lo_d;

  // A zero divisor already yields |a1| as remainder; only the quotient needs forcing.
  always_comb begin
    div_res = neg_q ? -div_mag : div_mag;
    if (div_zero_q && !rem_sel_q) begin
      div_res = '1;
    end
  end

  assign result_o = is_div_q ? div_res :
                    (hi_sel_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0]);
  assign done_o   = busy_q && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      is_div_q   <= st_div;
      hi_sel_q   <= (op_i != OP_MUL);
      rem_sel_q  <= st_rem;
      neg_q      <= st_rem ? a_neg : (a_neg ^ b_neg);
      div_zero_q <= (a2_i == '0);
      acc_q      <= '0;
      lo_q       <= a_mag;
      opnd_q     <= b_mag;
    end else if (busy_q) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle base ops, optional bit-serial M ops.
// Define ITER_ALU_MULDIV_EN to build the multiply/divide unit; otherwise M ops report illegal.
module iter_alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  iter_alu_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] y_q, y_d;
  logic            zero_q, zero_d;
  logic            s_less_q, s_less_d;
  logic            u_less_q, u_less_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] base_y;
  logic            base_illegal;
  logic [SHW-1:0]  shamt;
  logic            s_less_c, u_less_c;
  logic            accept, mop_sel, md_done;
  logic [XLEN-1:0] md_result;

  assign accept   = (state_q == ST_IDLE) && bus.in_valid;
  assign shamt    = bus.a2[SHW-1:0];
  assign s_less_c = $signed(bus.a1) < $signed(bus.a2);
  assign u_less_c = bus.a1 < bus.a2;

  always_comb begin
    base_y       = '0;
    base_illegal = 1'b0;
    case (bus.op)
      OP_ADD:  base_y = bus.a1 + bus.a2;
      OP_SUB:  base_y = bus.a1 - bus.a2;
      OP_XOR:  base_y = bus.a1 ^ bus.a2;
      OP_OR:   base_y = bus.a1 | bus.a2;
      OP_AND:  base_y = bus.a1 & bus.a2;
      OP_SLL:  base_y = bus.a1 << shamt;
      OP_SRL:  base_y = bus.a1 >> shamt;
      OP_SRA:  base_y = $signed(bus.a1) >>> shamt;
      OP_SLT:  base_y = {{(XLEN-1){1'b0}}, s_less_c};
      OP_SLTU: base_y = {{(XLEN-1){1'b0}}, u_less_c};
      default: base_illegal = 1'b1;
    endcase
  end

`ifdef ITER_ALU_MULDIV_EN
  logic md_start;

  assign mop_sel  = is_mop(bus.op);
  assign md_start = accept && mop_sel;

  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .op_i     (bus.op),
    .a1_i     (bus.a1),
    .a2_i     (bus.a2),
    .done_o   (md_done),
    .result_o (md_result)
  );
`else
  assign mop_sel   = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  // Compare flags are latched at accept; y/zero/illegal at completion.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    zero_d    = zero_q;
    s_less_d  = s_less_q;
    u_less_d  = u_less_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          s_less_d = s_less_c;
          u_less_d = u_less_c;
          if (mop_sel) begin
            state_d = ST_BUSY;
          end else begin
            state_d   = ST_DONE;
            y_d       = base_y;
            zero_d    = (base_y == '0);
            illegal_d = base_illegal;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          state_d   = ST_DONE;
          y_d       = md_result;
          zero_d    = (md_result == '0);
          illegal_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      y_q       <= '0;
      zero_q    <= 1'b0;
      s_less_q  <= 1'b0;
      u_less_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      zero_q    <= zero_d;
      s_less_q  <= s_less_d;
      u_less_q  <= u_less_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.s_less    = s_less_q;
  assign bus.u_less    = u_less_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu at XLEN=64; M-op expectations follow ITER_ALU_MULDIV_EN.
module tb_iter_alu;
  import alu_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

  typedef struct packed {
    logic [4:0]  op;
    logic [63:0] a1;
    logic [63:0] a2;
    logic [63:0] y;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  iter_alu_if #(.XLEN(64)) bus ();

  iter_alu #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for out_valid; lat=-1 on timeout.
  task automatic run_op(input logic [4:0] o, input logic [63:0] x, input logic [63:0] z,
                        output int lat, output int rdy_seen);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.a1        = x;
    bus.a2        = z;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat      = 1;
    rdy_seen = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_seen++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    $display("txn op=%05b a1=%h a2=%h y=%h zero=%b slt=%b ult=%b ill=%b lat=%0d",
             o, x, z, bus.y, bus.zero, bus.s_less, bus.u_less, bus.illegal, lat);
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.a1 = '0; bus.a2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.y !== 64'd0) begin failures++; $display("FAIL reset_y: got %h expected 0", bus.y); end
    checks++; if ({bus.zero, bus.s_less, bus.u_less, bus.illegal} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {bus.zero, bus.s_less, bus.u_less, bus.illegal});
    end
  endtask

  task automatic test_add_flags();
    int lat, rdy;
    run_op(OP_ADD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, lat, rdy);
    checks++; if (lat !== 1) begin failures++; $display("FAIL add_latency: got %0d expected 1", lat); end
    checks++; if (bus.y !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL add_y: got %h expected fffffffffffffffe", bus.y); end
    checks++; if (bus.s_less !== 1'b0) begin failures++; $display("FAIL add_s_less: got %b expected 0", bus.s_less); end
    checks++; if (bus.u_less !== 1'b1) begin failures++; $display("FAIL add_u_less: got %b expected 1", bus.u_less); end
    checks++; if (bus.zero !== 1'b0) begin failures++; $display("FAIL add_zero: got %b expected 0", bus.zero); end
    finish_op();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_release: got out_valid=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_base_ops();
    vec_t v[12];
    int lat, rdy;
    v[0]  = '{OP_SUB,  64'd3, 64'd3, 64'd0};
    v[1]  = '{OP_XOR,  64'hF0F0, 64'h0FF0, 64'hFF00};
    v[2]  = '{OP_OR,   64'hF0, 64'h0F, 64'hFF};
    v[3]  = '{OP_AND,  64'hF0, 64'h3C, 64'h30};
    v[4]  = '{OP_SLL,  64'd1, 64'd65, 64'd2};
    v[5]  = '{OP_SRL,  MINN, 64'd68, 64'h0800_0000_0000_0000};
    v[6]  = '{OP_SRA,  MINN, 64'd4, 64'hF800_0000_0000_0000};
    v[7]  = '{OP_SRA,  64'h7000_0000_0000_0000, 64'd127, 64'd0};
    v[8]  = '{OP_SLT,  ONES, 64'd1, 64'd1};
    v[9]  = '{OP_SLTU, ONES, 64'd1, 64'd0};
    v[10] = '{OP_SUB,  64'd0, 64'd1, ONES};
    v[11] = '{OP_ADD,  ONES, 64'd1, 64'd0};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, v[i].a1, v[i].a2, lat, rdy);
      checks++; if (lat !== 1) begin failures++; $display("FAIL base_latency[%0d]: got %0d expected 1", i, lat); end
      checks++; if (bus.y !== v[i].y) begin failures++; $display("FAIL base_y[%0d]: got %h expected %h", i, bus.y, v[i].y); end
      checks++; if (bus.zero !== (v[i].y == 64'd0)) begin failures++; $display("FAIL base_zero[%0d]: got %b expected %b", i, bus.zero, v[i].y == 64'd0); end
      checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL base_illegal[%0d]: got %b expected 0", i, bus.illegal); end
      finish_op();
    end
  endtask

  task automatic test_illegal();
    int lat, rdy;
    run_op(5'b11111, 64'd12, 64'd34, lat, rdy);
    checks++; if (lat !== 1) begin failures++; $display("FAIL illegal_latency: got %0d expected 1", lat); end
    checks++; if (bus.y !== 64'd0) begin failures++; $display("FAIL illegal_y: got %h expected 0", bus.y); end
    checks++; if (bus.illegal !== 1'b1) begin failures++; $display("FAIL illegal_flag: got %b expected 1", bus.illegal); end
    checks++; if (bus.zero !== 1'b1) begin failures++; $display("FAIL illegal_zero: got %b expected 1", bus.zero); end
    finish_op();
  endtask

  task automatic test_hold();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_ADD; bus.a1 = 64'd10; bus.a2 = 64'd20; bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    // keep requesting a different op while the result is held
    bus.op = OP_SUB; bus.a1 = 64'd1; bus.a2 = 64'd1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.y !== 64'd30) begin
        failures++; $display("FAIL hold_y[%0d]: got valid=%b y=%h expected valid=1 y=1e", i, bus.out_valid, bus.y);
      end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    $display("txn hold op=%05b y=%h", OP_ADD, bus.y);
    finish_op();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.y !== 64'd30) begin failures++; $display("FAIL hold_no_capture: got %h expected 1e", bus.y); end
  endtask

  task automatic test_back_to_back();
    int lat, rdy;
    run_op(OP_ADD, 64'd100, 64'd23, lat, rdy);
    checks++; if (bus.y !== 64'd123 || lat !== 1) begin failures++; $display("FAIL b2b_first: got y=%h lat=%0d expected y=7b lat=1", bus.y, lat); end
    finish_op();
    run_op(OP_XOR, 64'hAAAA, 64'h5555, lat, rdy);
    checks++; if (bus.y !== 64'hFFFF || lat !== 1) begin failures++; $display("FAIL b2b_second: got y=%h lat=%0d expected y=ffff lat=1", bus.y, lat); end
    finish_op();
  endtask

`ifdef ITER_ALU_MULDIV_EN
  task automatic test_muldiv();
    vec_t v[17];
    int lat, rdy;
    v[0]  = '{OP_DIVU,  64'd100, 64'd7, 64'd14};
    v[1]  = '{OP_REMU,  64'd100, 64'd7, 64'd2};
    v[2]  = '{OP_DIV,   MINN, ONES, MINN};
    v[3]  = '{OP_REM,   MINN, ONES, 64'd0};
    v[4]  = '{OP_DIVU,  64'd9, 64'd0, ONES};
    v[5]  = '{OP_REMU,  64'd9, 64'd0, 64'd9};
    v[6]  = '{OP_DIV,   64'hFFFF_FFFF_FFFF_FFF7, 64'd0, ONES};
    v[7]  = '{OP_REM,   64'hFFFF_FFFF_FFFF_FFF7, 64'd0, 64'hFFFF_FFFF_FFFF_FFF7};
    v[8]  = '{OP_DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
    v[9]  = '{OP_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES};
    v[10] = '{OP_DIV,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2};
    v[11] = '{OP_REM,   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2};
    v[12] = '{OP_MULH,  ONES, ONES, 64'd0};
    v[13] = '{OP_MULHU, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE};
    v[14] = '{OP_MUL,   ONES, ONES, 64'd1};
    v[15] = '{OP_MULH,  MINN, 64'd2, ONES};
    v[16] = '{OP_MUL,   64'd123456789, 64'd1000, 64'd123456789000};
    for (int i = 0; i < 17; i++) begin
      run_op(v[i].op, v[i].a1, v[i].a2, lat, rdy);
      checks++; if (lat !== 65) begin failures++; $display("FAIL md_latency[%0d]: got %0d expected 65", i, lat); end
      checks++; if (rdy !== 0) begin failures++; $display("FAIL md_busy_ready[%0d]: got %0d ready cycles expected 0", i, rdy); end
      checks++; if (bus.y !== v[i].y) begin failures++; $display("FAIL md_y[%0d]: got %h expected %h", i, bus.y, v[i].y); end
      checks++; if (bus.zero !== (v[i].y == 64'd0) || bus.illegal !== 1'b0) begin
        failures++; $display("FAIL md_flags[%0d]: got zero=%b ill=%b expected zero=%b ill=0", i, bus.zero, bus.illegal, v[i].y == 64'd0);
      end
      if (i == 8) begin
        checks++; if (bus.s_less !== 1'b1 || bus.u_less !== 1'b0) begin
          failures++; $display("FAIL md_cmp: got s=%b u=%b expected s=1 u=0", bus.s_less, bus.u_less);
        end
      end
      finish_op();
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.a1 = 64'd100; bus.a2 = 64'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL abort_busy_ready: got %b expected 0", bus.in_ready); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL abort_release: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    $display("txn abort op=%05b y=%h", OP_DIVU, bus.y);
    checks++; if (seen !== 0 || bus.y !== 64'd0) begin failures++; $display("FAIL abort_discard: got valid_cycles=%0d y=%h expected 0 and 0", seen, bus.y); end
  endtask
`else
  task automatic test_muldiv();
    int lat, rdy;
    run_op(OP_MUL, 64'd3, 64'd5, lat, rdy);
    checks++; if (lat !== 1) begin failures++; $display("FAIL nomd_latency: got %0d expected 1", lat); end
    checks++; if (bus.illegal !== 1'b1) begin failures++; $display("FAIL nomd_illegal: got %b expected 1", bus.illegal); end
    checks++; if (bus.y !== 64'd0) begin failures++; $display("FAIL nomd_y: got %h expected 0", bus.y); end
    finish_op();
    run_op(OP_DIVU, 64'd100, 64'd7, lat, rdy);
    checks++; if (lat !== 1 || bus.illegal !== 1'b1) begin failures++; $display("FAIL nomd_divu: got lat=%0d ill=%b expected lat=1 ill=1", lat, bus.illegal); end
    finish_op();
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_ADD; bus.a1 = 64'd1; bus.a2 = 64'd2;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL abort_done_valid: got %b expected 1", bus.out_valid); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk);
    #1;
    $display("txn abort op=%05b y=%h", OP_ADD, bus.y);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL abort_release: got valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    checks++; if (bus.y !== 64'd0) begin failures++; $display("FAIL abort_y: got %h expected 0", bus.y); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add_flags();
    test_base_ops();
    test_illegal();
    test_hold();
    test_back_to_back();
    test_muldiv();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
